// File: rtl/truth_table_sweeper_if.sv
// Host-side control and result bundle for truth_table_sweeper.
// The host drives start/abort; the sweeper returns status and the captured word.
interface truth_table_sweeper_if #(
  parameter int W = 8
);
  logic         start;
  logic         abort;
  logic         busy;
  logic         done;
  logic         pass;
  logic [W-1:0] tt_word;

  modport master (
    output start,
    output abort,
    input  busy,
    input  done,
    input  pass,
    input  tt_word
  );

  modport slave (
    input  start,
    input  abort,
    output busy,
    output done,
    output pass,
    output tt_word
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives a small gate through every input vector, samples its output
// after a settle window and checks the packed truth table.
module truth_table_sweeper #(
  parameter int N_INPUTS = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [(2**N_INPUTS)-1:0] EXPECTED = 8'h23
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lut_out,
  output logic [N_INPUTS-1:0] lut_in,
  truth_table_sweeper_if.slave host
);

  localparam int W  = 2 ** N_INPUTS;
  localparam int IW = $clog2(W + 1);
  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IW-1:0] ILAST = IW'(W - 1);
  localparam logic [CW-1:0] CLAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  tt;
  logic [W-1:0]  tt_next;
  logic          pass;
  logic          sample;
  logic          last;
  logic          go;
  logic [N_INPUTS-1:0] pos;

  assign go     = host.start && !host.abort;
  assign sample = (state == SETTLE) && (cnt == CLAST);
  assign last   = (idx == ILAST);
  assign pos    = N_INPUTS'(ILAST - idx);

  // Truth-table word with the current sample folded in (MSB = vector 0).
  always_comb begin
    tt_next      = tt;
    tt_next[pos] = lut_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic; abort always returns to IDLE from an active sweep.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (go) nxt = SETTLE;
      SETTLE: begin
        if (host.abort)        nxt = IDLE;
        else if (sample && last) nxt = DONE;
      end
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status outputs decode the registered state only.
  always_comb begin
    host.busy    = (state != IDLE);
    host.done    = (state == DONE);
    host.pass    = pass;
    host.tt_word = tt;
  end

  // Sweep datapath: vector index, settle counter, captured word and verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      cnt    <= '0;
      lut_in <= '0;
      tt     <= '0;
      pass   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            idx    <= '0;
            cnt    <= '0;
            lut_in <= '0;
            tt     <= '0;
            pass   <= 1'b0;
          end
        end
        SETTLE: begin
          if (host.abort) begin
            idx    <= '0;
            cnt    <= '0;
            lut_in <= '0;
            pass   <= 1'b0;
          end else if (sample) begin
            tt <= tt_next;
            if (last) begin
              pass <= (tt_next == EXPECTED);
            end else begin
              idx    <= idx + 1'b1;
              lut_in <= N_INPUTS'(idx + 1'b1);
              cnt    <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          lut_in <= '0;
          if (host.abort) pass <= 1'b0;
        end
        default: begin
          lut_in <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper at SETTLE_CYCLES 4 and 1.
// Gate models are driven combinationally from each instance's lut_in.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   total = 0;
  int   mode = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.W(8)) ha ();
  truth_table_sweeper_if #(.W(8)) hb ();

  logic [2:0] in_a;
  logic [2:0] in_b;
  logic       out_a;
  logic       out_b;

  function automatic logic gate(input int m, input logic [2:0] v);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return (v == 3'd2) || (v == 3'd6) || (v == 3'd7);
  endfunction

  assign out_a = gate(mode, in_a);
  assign out_b = gate(mode, in_b);

  truth_table_sweeper #(
    .N_INPUTS(3), .SETTLE_CYCLES(4), .EXPECTED(8'h23)
  ) dut_a (
    .clk(clk), .reset(reset), .lut_out(out_a),
    .lut_in(in_a), .host(ha.slave)
  );

  truth_table_sweeper #(
    .N_INPUTS(3), .SETTLE_CYCLES(1), .EXPECTED(8'h23)
  ) dut_b (
    .clk(clk), .reset(reset), .lut_out(out_b),
    .lut_in(in_b), .host(hb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on instance w (0: S=4, 1: S=1); optional mid-sweep starts.
  task automatic sweep(input int w, input int s, input bit extra,
                       input logic [7:0] ew, input logic ep);
    int n;
    int dn;
    int dones;
    bit step_ok;
    logic [2:0] li;
    n = 0; dn = -1; dones = 0; step_ok = 1'b1;
    if (w == 0) ha.start = 1'b1; else hb.start = 1'b1;
    tick();
    ha.start = 1'b0; hb.start = 1'b0;
    chk("busy_after_start", (w == 0) ? ha.busy : hb.busy, 1);
    while (n <= 8 * s + 6) begin
      li = (w == 0) ? in_a : in_b;
      if (dn < 0 && n < 8 * s && li !== 3'(n / s)) step_ok = 1'b0;
      if ((w == 0) ? ha.done : hb.done) begin
        dones++;
        if (dn < 0) dn = n;
      end
      if (extra && (n == 4 || n == 19)) begin
        if (w == 0) ha.start = 1'b1; else hb.start = 1'b1;
      end else begin
        ha.start = 1'b0; hb.start = 1'b0;
      end
      tick();
      n++;
    end
    ha.start = 1'b0; hb.start = 1'b0;
    chk("lut_in_steps", step_ok, 1);
    chk("done_latency", dn, 8 * s);
    chk("done_count", dones, 1);
    chk("tt_word", (w == 0) ? ha.tt_word : hb.tt_word, ew);
    chk("pass", (w == 0) ? ha.pass : hb.pass, ep);
    chk("busy_idle", (w == 0) ? ha.busy : hb.busy, 0);
    chk("lut_in_idle", (w == 0) ? in_a : in_b, 0);
  endtask

  initial begin
    int dones;
    ha.start = 1'b0; ha.abort = 1'b0;
    hb.start = 1'b0; hb.abort = 1'b0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_busy", ha.busy, 0);
    chk("rst_done", ha.done, 0);
    chk("rst_pass", ha.pass, 0);
    chk("rst_tt", ha.tt_word, 0);
    chk("rst_lut_in", in_a, 0);
    reset = 1'b0;
    tick();

    mode = 0; sweep(0, 4, 1'b0, 8'h23, 1'b1);
    mode = 1; sweep(0, 4, 1'b0, 8'h00, 1'b0);
    mode = 2; sweep(0, 4, 1'b0, 8'hFF, 1'b0);
    mode = 0; sweep(1, 1, 1'b0, 8'h23, 1'b1);
    mode = 0; sweep(0, 4, 1'b1, 8'h23, 1'b1);

    // Reset ten edges into a sweep.
    ha.start = 1'b1; tick(); ha.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstmid_busy", ha.busy, 0);
    chk("rstmid_lut_in", in_a, 0);
    chk("rstmid_tt", ha.tt_word, 0);
    chk("rstmid_pass", ha.pass, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (ha.done) dones++;
      tick();
    end
    chk("rstmid_no_done", dones, 0);
    sweep(0, 4, 1'b0, 8'h23, 1'b1);

    // Abort after five vectors have been sampled.
    ha.start = 1'b1; tick(); ha.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    ha.abort = 1'b1; tick(); ha.abort = 1'b0;
    chk("abort_busy", ha.busy, 0);
    chk("abort_tt", ha.tt_word, 8'h20);
    chk("abort_pass", ha.pass, 0);
    chk("abort_lut_in", in_a, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (ha.done) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);

    // Abort together with start in IDLE: nothing starts.
    ha.start = 1'b1; ha.abort = 1'b1; tick();
    ha.start = 1'b0; ha.abort = 1'b0;
    chk("abort_start_idle", ha.busy, 0);
    tick();
    chk("abort_start_idle2", ha.busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
